fsm_multiplier_param: RTL and testbench

FSM_MULTIPLIER_PARAM -- requirements
Module: fsm_multiplier_param

---
 rtl/fsm_multiplier_param.sv | 195 +++++++++++++++++++
 tb/tb_fsm_multiplier_param.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_multiplier_param.sv
// Multi-cycle schoolbook multiplier: operands arrive one W-bit chunk per beat (LSB first),
// rows of n_i*m_j are accumulated one step per cycle, and the product leaves one chunk per handshake.
module fsm_multiplier_param #(
  parameter int REGISTER_SIZE = 32,
  parameter int BITS_IN_NUM   = 2048,
  parameter int LOW_HALF_ONLY = 0
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [REGISTER_SIZE-1:0] n_in,
  input  logic [REGISTER_SIZE-1:0] m_in,
  input  logic                     valid_in,
  output logic                     ready_out,
  output logic [REGISTER_SIZE-1:0] data_out,
  output logic                     valid_out,
  output logic                     final_out,
  input  logic                     ready_in
);

  localparam int W      = REGISTER_SIZE;
  localparam int CHUNKS = BITS_IN_NUM / REGISTER_SIZE;
  localparam int ACC    = 2 * CHUNKS;
  localparam int NW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int CW     = $clog2(CHUNKS + 1);
  localparam int AW     = $clog2(ACC);
  localparam int P      = (LOW_HALF_ONLY != 0) ? CHUNKS : ACC;

  if ((BITS_IN_NUM % REGISTER_SIZE) != 0 || (BITS_IN_NUM / REGISTER_SIZE) < 2) begin : g_param_check
    $error("fsm_multiplier_param: BITS_IN_NUM must be a multiple of REGISTER_SIZE with at least 2 chunks");
  end

  typedef enum logic [1:0] {IDLE, LOAD, MULT, OUT} state_t;

  // Exact 2W-bit multiply-accumulate step; the sum cannot exceed 2^(2W)-1.
  function automatic logic [2*W-1:0] mac(input logic [W-1:0] a, input logic [W-1:0] n,
                                         input logic [W-1:0] m, input logic [W-1:0] c);
    return ((2*W)'(n) * (2*W)'(m)) + (2*W)'(a) + (2*W)'(c);
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   i_q, i_d;
  logic [NW-1:0]   j_q, j_d;
  logic [W-1:0]    c_q, c_d;
  logic [AW-1:0]   widx_q, widx_d;
  logic            valid_q, valid_d;
  logic            final_q, final_d;
  logic [W-1:0]    data_q, data_d;

  logic [W-1:0]    n_q   [CHUNKS];
  logic [W-1:0]    n_d   [CHUNKS];
  logic [W-1:0]    m_q   [CHUNKS];
  logic [W-1:0]    m_d   [CHUNKS];
  logic [W-1:0]    acc_q [ACC];
  logic [W-1:0]    acc_d [ACC];

  logic [NW-1:0]   col;
  logic [AW-1:0]   step_idx;
  logic [AW-1:0]   hi_idx;
  logic [CW-1:0]   last_col;
  logic [2*W-1:0]  sum;

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    c_d      = c_q;
    widx_d   = widx_q;
    valid_d  = valid_q;
    final_d  = final_q;
    data_d   = data_q;
    n_d      = n_q;
    m_d      = m_q;
    acc_d    = acc_q;

    col      = i_q[NW-1:0];
    step_idx = AW'(i_q) + AW'(j_q);
    hi_idx   = AW'(j_q) + AW'(CHUNKS);
    last_col = CW'(CHUNKS - 1) - CW'(j_q);
    sum      = mac(acc_q[step_idx], n_q[col], m_q[j_q], c_q);

    unique case (state_q)
      IDLE: begin
        if (valid_in) begin
          acc_d   = '{default: '0};
          n_d[0]  = n_in;
          m_d[0]  = m_in;
          i_d     = CW'(1);
          state_d = LOAD;
        end
      end

      LOAD: begin
        if (valid_in) begin
          n_d[col] = n_in;
          m_d[col] = m_in;
          if (i_q == CW'(CHUNKS - 1)) begin
            state_d = MULT;
            i_d     = '0;
            j_d     = '0;
            c_d     = '0;
          end else begin
            i_d = i_q + CW'(1);
          end
        end
      end

      MULT: begin
        // Full mode: column CHUNKS of each row is the carry write-back cycle.
        if (LOW_HALF_ONLY == 0 && i_q == CW'(CHUNKS)) begin
          acc_d[hi_idx] = c_q;
          c_d = '0;
          i_d = '0;
          if (j_q == NW'(CHUNKS - 1)) begin
            state_d = OUT;
          end else begin
            j_d = j_q + NW'(1);
          end
        end else begin
          acc_d[step_idx] = sum[W-1:0];
          c_d = sum[2*W-1:W];
          if (LOW_HALF_ONLY != 0 && i_q == last_col) begin
            c_d = '0;
            i_d = '0;
            if (j_q == NW'(CHUNKS - 1)) begin
              state_d = OUT;
            end else begin
              j_d = j_q + NW'(1);
            end
          end else begin
            i_d = i_q + CW'(1);
          end
        end
        if (state_d == OUT) begin
          valid_d = 1'b1;
          final_d = 1'b0;
          widx_d  = '0;
          data_d  = acc_d[0];
        end
      end

      OUT: begin
        if (ready_in) begin
          if (final_q) begin
            state_d = IDLE;
            valid_d = 1'b0;
            final_d = 1'b0;
            data_d  = '0;
            widx_d  = '0;
          end else begin
            widx_d  = widx_q + AW'(1);
            data_d  = acc_q[widx_d];
            final_d = (widx_d == AW'(P - 1));
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      c_q     <= '0;
      widx_q  <= '0;
      valid_q <= 1'b0;
      final_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      c_q     <= c_d;
      widx_q  <= widx_d;
      valid_q <= valid_d;
      final_q <= final_d;
      data_q  <= data_d;
    end
  end

  // Operand and accumulator storage is fully rewritten by every new operation, so it needs no reset.
  always_ff @(posedge clk_in) begin
    n_q   <= n_d;
    m_q   <= m_d;
    acc_q <= acc_d;
  end

  assign ready_out = (state_q == IDLE) || (state_q == LOAD);
  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign final_out = final_q;

endmodule

// File: tb/tb_fsm_multiplier_param.sv
// Bench for fsm_multiplier_param at W=8, 32-bit operands: a full-product instance and a low-half instance,
// checked every cycle against a product model plus literal expected results.
module tb_fsm_multiplier_param;

  logic clk;
  logic rst_n;

  logic [7:0] n0, m0, dout0, n1, m1, dout1;
  logic vin0, rdy0, rout0, vout0, fin0;
  logic vin1, rdy1, rout1, vout1, fin1;

  int ncmp;
  int nerr;

  logic [63:0] exp_prod [2];
  logic [63:0] got      [2];
  int          arm_cnt  [2];
  int          done_cnt [2];
  int          idx      [2];
  bit          mute     [2];
  logic        pv [2];
  logic        pr [2];
  logic        pf [2];
  logic [7:0]  pd [2];

  fsm_multiplier_param #(.REGISTER_SIZE(8), .BITS_IN_NUM(32), .LOW_HALF_ONLY(0)) dut (
    .clk_in(clk), .rst_in(rst_n), .n_in(n0), .m_in(m0), .valid_in(vin0), .ready_out(rout0),
    .data_out(dout0), .valid_out(vout0), .final_out(fin0), .ready_in(rdy0)
  );

  fsm_multiplier_param #(.REGISTER_SIZE(8), .BITS_IN_NUM(32), .LOW_HALF_ONLY(1)) dut_lh (
    .clk_in(clk), .rst_in(rst_n), .n_in(n1), .m_in(m1), .valid_in(vin1), .ready_out(rout1),
    .data_out(dout1), .valid_out(vout1), .final_out(fin1), .ready_in(rdy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic get_vout(input int d);
    return (d == 0) ? vout0 : vout1;
  endfunction

  function automatic logic get_rout(input int d);
    return (d == 0) ? rout0 : rout1;
  endfunction

  task automatic set_in(input int d, input logic v, input logic [7:0] n, input logic [7:0] m);
    if (d == 0) begin vin0 = v; n0 = n; m0 = m; end
    else begin vin1 = v; n1 = n; m1 = m; end
  endtask

  task automatic set_rdy(input int d, input logic r);
    if (d == 0) rdy0 = r;
    else rdy1 = r;
  endtask

  // Per-cycle check of one instance against the expected product, sampled on the falling edge.
  task automatic chk(input int d, input logic v, input logic f, input logic [7:0] dat, input logic r);
    int p;
    logic [7:0] ew;
    p = (d == 1) ? 4 : 8;
    if (mute[d]) begin
      pv[d] = 1'b0;
      return;
    end
    if (v !== 1'b1) begin
      ncmp++;
      if (dat !== 8'h00 || f !== 1'b0) begin
        nerr++;
        $display("FAIL idle_zero[%0d]: data=%h final=%b, want data=00 final=0", d, dat, f);
      end
    end
    if (pv[d] && !pr[d]) begin
      ncmp++;
      if (v !== 1'b1 || dat !== pd[d] || f !== pf[d]) begin
        nerr++;
        $display("FAIL hold[%0d]: v=%b data=%h final=%b, want v=1 data=%h final=%b", d, v, dat, f, pd[d], pf[d]);
      end
    end
    if (arm_cnt[d] == done_cnt[d]) begin
      ncmp++;
      if (v !== 1'b0) begin
        nerr++;
        $display("FAIL unexpected_word[%0d]: valid_out=%b data=%h, want valid_out=0", d, v, dat);
      end
    end else if (v === 1'b1) begin
      ew = exp_prod[d][8*idx[d] +: 8];
      ncmp++;
      if (dat !== ew || f !== (idx[d] == p - 1)) begin
        nerr++;
        $display("FAIL word[%0d][%0d]: data=%h final=%b, want data=%h final=%b",
                 d, idx[d], dat, f, ew, (idx[d] == p - 1));
      end
      if (r) begin
        got[d][8*idx[d] +: 8] = dat;
        if (idx[d] == p - 1) begin
          idx[d] = 0;
          done_cnt[d]++;
        end else begin
          idx[d]++;
        end
      end
    end
    pv[d] = v;
    pr[d] = r;
    pd[d] = dat;
    pf[d] = f;
  endtask

  always @(negedge clk) begin
    chk(0, vout0, fin0, dout0, rdy0);
    chk(1, vout1, fin1, dout1, rdy1);
  end

  task automatic check_bit(input string name, input logic act, input logic req);
    ncmp++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %b, want %b", name, act, req);
    end
  endtask

  // Called at posedge+1; leaves the bench at posedge+1 just after the last beat was captured.
  task automatic load(input int d, input logic [31:0] n, input logic [31:0] m, input bit gaps);
    for (int k = 0; k < 4; k++) begin
      if (gaps) begin
        set_in(d, 1'b0, 8'($urandom), 8'($urandom));
        repeat (k + 1) begin @(posedge clk); #1; end
      end
      set_in(d, 1'b1, n[8*k +: 8], m[8*k +: 8]);
      check_bit("ready_at_beat", get_rout(d), 1'b1);
      @(posedge clk); #1;
    end
    set_in(d, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic drain(input int d, input logic [31:0] n, input logic [31:0] m, input bit tog,
                       input bit junk, input logic [63:0] lit);
    int cyc;
    int first;
    int lat;
    bit ok;
    lat = (d == 1) ? 10 : 20;
    exp_prod[d] = {32'h0, n} * {32'h0, m};
    arm_cnt[d]++;
    set_rdy(d, tog ? 1'b0 : 1'b1);
    cyc = 0;
    first = 0;
    ok = 1'b0;
    while (cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (first == 0 && get_vout(d)) first = cyc;
      if (done_cnt[d] == arm_cnt[d]) begin
        ok = 1'b1;
        break;
      end
      set_rdy(d, tog ? ((cyc % 2) == 1) : 1'b1);
      if (junk) set_in(d, 1'b1, 8'($urandom), 8'($urandom));
    end
    set_in(d, 1'b0, 8'h00, 8'h00);
    set_rdy(d, 1'b1);
    ncmp++;
    if (!ok) begin
      nerr++;
      $display("FAIL timeout[%0d]: words=%0d after %0d cycles, want all", d, idx[d], cyc);
    end
    ncmp++;
    if (first != lat) begin
      nerr++;
      $display("FAIL latency[%0d]: first valid_out %0d edges after last beat, want %0d", d, first, lat);
    end
    ncmp++;
    if ((d == 1 && got[1][31:0] !== lit[31:0]) || (d == 0 && got[0] !== lit)) begin
      nerr++;
      $display("FAIL result[%0d]: got %h, want %h", d, got[d], lit);
    end
  endtask

  task automatic run_op(input int d, input logic [31:0] n, input logic [31:0] m, input bit gaps,
                        input bit tog, input bit junk, input logic [63:0] lit);
    load(d, n, m, gaps);
    drain(d, n, m, tog, junk, lit);
  endtask

  initial begin
    ncmp = 0;
    nerr = 0;
    for (int d = 0; d < 2; d++) begin
      arm_cnt[d] = 0;
      mute[d] = 1'b0;
    end
    set_in(0, 1'b0, 8'h00, 8'h00);
    set_in(1, 1'b0, 8'h00, 8'h00);
    rdy0 = 1'b1;
    rdy1 = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check_bit("rst_valid0", vout0, 1'b0);
    check_bit("rst_final0", fin0, 1'b0);
    check_bit("rst_data0_zero", dout0 == 8'h00, 1'b1);
    check_bit("rst_ready0", rout0, 1'b1);
    check_bit("rst_valid1", vout1, 1'b0);
    check_bit("rst_ready1", rout1, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 64'hFFFFFFFE00000001);
    run_op(0, 32'h00000003, 32'h00000005, 1'b1, 1'b0, 1'b0, 64'h000000000000000F);
    run_op(0, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1, 1'b0, 64'h0B00EA4E242D2080);
    run_op(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 64'h0000000000000001);
    run_op(1, 32'h00001234, 32'h00000100, 1'b1, 1'b1, 1'b1, 64'h0000000000123400);

    // Junk on valid_in during MULT/OUT, then a back-to-back operation.
    run_op(0, 32'h00010000, 32'h00000100, 1'b0, 1'b0, 1'b1, 64'h0000000001000000);
    run_op(0, 32'h000000FF, 32'h000000FF, 1'b0, 1'b0, 1'b0, 64'h000000000000FE01);

    // Reset in the middle of MULT.
    load(0, 32'h11223344, 32'h55667788, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_bit("midmult_rst_valid", vout0, 1'b0);
    check_bit("midmult_rst_final", fin0, 1'b0);
    check_bit("midmult_rst_data_zero", dout0 == 8'h00, 1'b1);
    check_bit("midmult_rst_ready", rout0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_bit("midmult_release_ready", rout0, 1'b1);
    repeat (30) @(posedge clk);
    #1;
    run_op(0, 32'h00000002, 32'h00000003, 1'b0, 1'b0, 1'b0, 64'h0000000000000006);

    // Reset while a word is being held in OUT.
    mute[0] = 1'b1;
    set_rdy(0, 1'b0);
    load(0, 32'hCAFEF00D, 32'h87654321, 1'b0);
    repeat (25) @(posedge clk);
    #1;
    check_bit("midout_valid_before_rst", vout0, 1'b1);
    rst_n = 1'b0;
    #1;
    check_bit("midout_rst_valid", vout0, 1'b0);
    check_bit("midout_rst_data_zero", dout0 == 8'h00, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    set_rdy(0, 1'b1);
    @(posedge clk); #1;
    mute[0] = 1'b0;
    check_bit("midout_release_ready", rout0, 1'b1);
    repeat (30) @(posedge clk);
    #1;
    run_op(0, 32'h00000002, 32'h00000003, 1'b0, 1'b0, 1'b0, 64'h0000000000000006);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      done_cnt[d] = 0;
      idx[d] = 0;
      got[d] = '0;
      pv[d] = 1'b0;
      pr[d] = 1'b1;
      pf[d] = 1'b0;
      pd[d] = 8'h00;
    end
  end

endmodule
